dma_read_engine: RTL and testbench

AXI4 read-master DMA engine, the memory-to-stream counterpart of the write-side dma_master_engine. On a start pulse it reads i_total_len bytes from i_base_addr as INCR bursts and pushes each 32-bit beat into a downstream FIFO-style write port. That port feeds the 32->128 gearbox ahead of the crypto engine. It holds one burst outstanding at a time, never crosses a 4 KB boundary, and reports done/error to the CSR block.

---
 rtl/dma_read_engine.sv | 189 ++++++++++++++++++
 tb/tb_dma_read_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// dma_read_engine: AXI4 read-master DMA. On i_start it reads i_total_len bytes from
// i_base_addr as INCR bursts (one outstanding, never crossing 4 KB) and forwards each
// 32-bit beat to a downstream FIFO write port with zero added latency.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_start            one-cycle start pulse (ignored while busy)
//   i_base_addr        source byte address, bits[1:0] ignored
//   i_total_len        length in bytes, bits[1:0] ignored
//   o_busy / o_done    busy level / one-cycle completion pulse
//   o_error            sticky error (bad rresp or rlast mismatch), cleared on start
//   o_fifo_wdata/wen   downstream write port; i_fifo_full back-pressures the R channel
//   m_axi_ar*/r*       AXI4 read address and read data channels
//   o_perf_stall       stall counter, only live when DMA_RD_PERF_CNT_EN is defined,
//                      otherwise tied to zero

module dma_read_engine #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic                  o_fifo_wen,
    input  logic                  i_fifo_full,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [31:0]           o_perf_stall
);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAddr,
        StData,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [29:0]           beats_left_q, beats_left_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  error_q, error_d;

    logic [31:0] room;
    logic [31:0] burst;
    logic [31:0] burst_bytes;
    logic        last_exp;

    // Byte-address and length LSBs are don't-care by definition.
    logic unused_lsbs;
    assign unused_lsbs = ^{i_base_addr[1:0], i_total_len[1:0]};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        arlen_d      = arlen_q;
        beat_cnt_d   = beat_cnt_q;
        error_d      = error_q;
        m_axi_rready = 1'b0;
        o_fifo_wen   = 1'b0;
        o_fifo_wdata = '0;

        // Beats remaining before the next 4 KB page boundary (1..1024).
        room = (32'd4096 - {20'd0, addr_q[11:0]}) >> 2;
        burst = {2'b00, beats_left_q};
        if (burst > MAX_BURST) burst = MAX_BURST;
        if (burst > room) burst = room;

        burst_bytes = ({24'd0, arlen_q} + 32'd1) << 2;
        last_exp    = (beat_cnt_q == arlen_q);

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    addr_d       = {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
                    beats_left_d = i_total_len[31:2];
                    error_d      = 1'b0;
                    state_d      = (i_total_len[31:2] == 30'd0) ? StFinish : StCalc;
                end
            end
            StCalc: begin
                arlen_d    = 8'(burst - 32'd1);
                beat_cnt_d = 8'd0;
                state_d    = StAddr;
            end
            StAddr: begin
                if (m_axi_arready) state_d = StData;
            end
            StData: begin
                m_axi_rready = !i_fifo_full;
                if (m_axi_rvalid && !i_fifo_full) begin
                    o_fifo_wen   = 1'b1;
                    o_fifo_wdata = m_axi_rdata;
                    beats_left_d = beats_left_q - 30'd1;
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                    if (m_axi_rresp != 2'b00) error_d = 1'b1;
                    if (m_axi_rlast != last_exp) error_d = 1'b1;
                    // Burst ends on the expected last beat or on an early rlast; either
                    // way no further beats of this burst are taken.
                    if (last_exp || m_axi_rlast) begin
                        addr_d  = addr_q + ADDR_WIDTH'(burst_bytes);
                        state_d = (error_d || beats_left_d == 30'd0) ? StFinish : StCalc;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            beats_left_q <= '0;
            arlen_q      <= '0;
            beat_cnt_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            arlen_q      <= arlen_d;
            beat_cnt_q   <= beat_cnt_d;
            error_q      <= error_d;
        end
    end

    assign o_busy        = (state_q != StIdle);
    assign o_done        = (state_q == StFinish);
    assign o_error       = error_q;
    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;

`ifdef DMA_RD_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        stall;

    always_comb begin
        stall  = ((state_q == StData) && m_axi_rvalid && i_fifo_full) ||
                 ((state_q == StAddr) && !m_axi_arready);
        perf_d = perf_q;
        if ((state_q == StIdle) && i_start) begin
            perf_d = '0;
        end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign o_perf_stall = perf_q;
`else
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_dma_read_engine.sv
module tb_dma_read_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_total_len;
    logic        o_busy, o_done, o_error;
    logic [31:0] o_fifo_wdata;
    logic        o_fifo_wen;
    logic        i_fifo_full;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0] o_perf_stall;

    always #5 clk = ~clk;

    dma_read_engine #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_BURST (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_total_len  (i_total_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_fifo_wdata (o_fifo_wdata),
        .o_fifo_wen   (o_fifo_wen),
        .i_fifo_full  (i_fifo_full),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .o_perf_stall (o_perf_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int g_beat   = 0;
    int err_beat = -1;
    bit tgl      = 1'b0;

    logic [31:0] exp_araddr_q[$];
    logic [7:0]  exp_arlen_q[$];
    logic [31:0] exp_wd_q[$];

    // Memory contents as seen by the bench's slave.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_burst(logic [31:0] a, logic [7:0] len);
        exp_araddr_q.push_back(a);
        exp_arlen_q.push_back(len);
        for (int i = 0; i <= int'(len); i++) exp_wd_q.push_back(mem_word(a + 32'(i * 4)));
    endtask

    task automatic check_reset_vals(string p);
        check({p, "_busy"},   32'(o_busy), 32'd0);
        check({p, "_done"},   32'(o_done), 32'd0);
        check({p, "_error"},  32'(o_error), 32'd0);
        check({p, "_wen"},    32'(o_fifo_wen), 32'd0);
        check({p, "_wdata"},  o_fifo_wdata, 32'd0);
        check({p, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
        check({p, "_araddr"}, m_axi_araddr, 32'd0);
        check({p, "_arlen"},  32'(m_axi_arlen), 32'd0);
        check({p, "_rready"}, 32'(m_axi_rready), 32'd0);
        check({p, "_perf"},   o_perf_stall, 32'd0);
    endtask

    // Start a transfer, wait for done, check flags and that every expected item arrived.
    task automatic run(string name, logic [31:0] base, logic [31:0] len, bit exp_err,
                       int budget);
        int cyc;
        int d0;
        @(posedge clk); #1;
        i_base_addr = base;
        i_total_len = len;
        i_start     = 1'b1;
        d0          = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        check({name, "_busy_rise"}, 32'(o_busy), 32'd1);
        check({name, "_err_clr"}, 32'(o_error), 32'd0);
        cyc = 0;
        while (!o_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, 32'(o_done), 32'd1);
        check({name, "_error"}, 32'(o_error), 32'(exp_err));
        @(negedge clk);
        check({name, "_busy_fall"}, 32'(o_busy), 32'd0);
        @(negedge clk);
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_ar_left"}, 32'(exp_araddr_q.size()), 32'd0);
        check({name, "_wd_left"}, 32'(exp_wd_q.size()), 32'd0);
    endtask

    // AXI read slave: samples handshakes mid-cycle, updates its outputs just after the edge.
    initial begin
        logic        ar_hs, r_hs;
        logic [31:0] ar_a, cur;
        logic [7:0]  ar_l;
        int          beats, idx;
        bit          active;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        i_fifo_full   = 1'b0;
        active = 1'b0;
        beats  = 0;
        idx    = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            ar_a  = m_axi_araddr;
            ar_l  = m_axi_arlen;
            r_hs  = m_axi_rvalid && m_axi_rready;
            @(posedge clk); #1;
            if (rst) begin
                active = 1'b0;
            end else begin
                if (r_hs) begin
                    idx++;
                    g_beat++;
                    if (idx == beats) active = 1'b0;
                end
                if (ar_hs) begin
                    cur    = ar_a;
                    beats  = int'(ar_l) + 1;
                    idx    = 0;
                    active = 1'b1;
                end
            end
            m_axi_arready = 1'b1;
            m_axi_rvalid  = active;
            m_axi_rdata   = active ? mem_word(cur + 32'(idx * 4)) : '0;
            m_axi_rresp   = (active && g_beat == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast   = active && (idx == beats - 1);
            i_fifo_full   = tgl ? ~i_fifo_full : 1'b0;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [31:0] ea;
        logic [7:0]  el;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_done) done_cnt++;
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_araddr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ar_unexpected: araddr 0x%08h arlen %0d, none expected",
                                 m_axi_araddr, m_axi_arlen);
                    end else begin
                        ea = exp_araddr_q.pop_front();
                        el = exp_arlen_q.pop_front();
                        check("araddr", m_axi_araddr, ea);
                        check("arlen", 32'(m_axi_arlen), 32'(el));
                        check("arsize", 32'(m_axi_arsize), 32'd2);
                        check("arburst", 32'(m_axi_arburst), 32'd1);
                    end
                end
                if (o_fifo_wen) begin
                    if (exp_wd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wdata_unexpected: got 0x%08h, none expected",
                                 o_fifo_wdata);
                    end else begin
                        ea = exp_wd_q.pop_front();
                        check("fifo_wdata", o_fifo_wdata, ea);
                    end
                end
                if (m_axi_rvalid) check("rready_vs_full", 32'(m_axi_rready), 32'(!i_fifo_full));
            end
        end
    end

    initial begin
        int cyc;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_total_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        push_burst(32'h0000_1000, 8'd15);
        run("single", 32'h0000_1000, 32'd64, 1'b0, 200);

        push_burst(32'h0000_0FF0, 8'd3);
        push_burst(32'h0000_1000, 8'd11);
        run("split4k", 32'h0000_0FF0, 32'd64, 1'b0, 200);

        push_burst(32'h0000_3000, 8'd15);
        push_burst(32'h0000_3040, 8'd1);
        run("len48", 32'h0000_3000, 32'h48, 1'b0, 200);

        push_burst(32'h0000_3000, 8'd15);
        push_burst(32'h0000_3040, 8'd1);
        run("len4a", 32'h0000_3002, 32'h4A, 1'b0, 200);

        run("len0", 32'h0000_4000, 32'd0, 1'b0, 2);

        tgl = 1'b1;
        push_burst(32'h0000_5000, 8'd15);
        run("fifo_tgl", 32'h0000_5000, 32'd64, 1'b0, 300);
        tgl = 1'b0;

        err_beat = g_beat + 2;
        push_burst(32'h0000_2000, 8'd15);
        run("rresp_err", 32'h0000_2000, 32'd192, 1'b1, 300);
        err_beat = -1;

        push_burst(32'h0000_6000, 8'd3);
        run("after_err", 32'h0000_6000, 32'd16, 1'b0, 200);

        // Reset in the middle of a burst.
        push_burst(32'h0000_7000, 8'd15);
        @(posedge clk); #1;
        i_base_addr = 32'h0000_7000;
        i_total_len = 32'd64;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 0;
        while (exp_wd_q.size() > 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_progress", 32'(exp_wd_q.size() <= 12), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_mid");
        exp_araddr_q.delete();
        exp_arlen_q.delete();
        exp_wd_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        push_burst(32'h0000_8000, 8'd7);
        run("after_rst", 32'h0000_8000, 32'd32, 1'b0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
